vector_reduce_packer: RTL and testbench



---
 rtl/vector_reduce_packer_pkg.sv | 26 ++
 rtl/vector_reduce_packer_if.sv | 40 ++++
 rtl/vector_reduce_packer_tree.sv | 49 ++++
 rtl/vector_reduce_packer.sv | 170 +++++++++++++++++
 tb/tb_vector_reduce_packer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_reduce_packer_pkg.sv
// ============================================================================
// Module      : vrp_pkg
// Description : Shared op encodings and lane-count width for vector_reduce_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vrp_pkg;

    localparam int VRP_N = 8;
    localparam int CNT_W = $clog2(VRP_N);

    localparam logic [7:0] OP_BYPASS = 8'd0;
    localparam logic [7:0] OP_SUM    = 8'd1;
    localparam logic [7:0] OP_MAX    = 8'd2;
    localparam logic [7:0] OP_MIN    = 8'd3;
    localparam logic [7:0] OP_NZCNT  = 8'd4;

    // Unknown opcodes fall back to bypass so stray firmware bytes never corrupt a pack.
    function automatic logic is_bypass(input logic [7:0] op);
        return (op == OP_BYPASS) || (op > OP_NZCNT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vector_reduce_packer_if.sv
// ============================================================================
// Module      : vector_reduce_packer_if
// Description : Trace-stream and config bus of vector_reduce_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vector_reduce_packer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4
) ();
    localparam int CID_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

    logic                  tracing;
    logic                  valid_in;
    logic                  eof_in;
    logic                  bof_in;
    logic [CID_W-1:0]      chainId_in;
    logic [7:0]            configId;
    logic [7:0]            configData;
    logic [DATA_WIDTH-1:0] vector_in  [N-1:0];
    logic [DATA_WIDTH-1:0] vector_out [N-1:0];
    logic [CID_W-1:0]      chainId_out;
    logic                  valid_out;
    logic                  eof_out;
    logic                  bof_out;

    modport master (
        output tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
        input  vector_out, chainId_out, valid_out, eof_out, bof_out
    );

    modport slave (
        input  tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
        output vector_out, chainId_out, valid_out, eof_out, bof_out
    );
endinterface

`default_nettype wire

// File: rtl/vector_reduce_packer_tree.sv
// ============================================================================
// Module      : vector_reduce_tree
// Description : Combinational N-lane reduction (sum / signed max / signed min / nonzero count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_reduce_tree
    import vrp_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [7:0]            i_op,
    input  wire logic [DATA_WIDTH-1:0] i_vec [N-1:0],
    output logic      [DATA_WIDTH-1:0] o_result
);

    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_max;
    logic [DATA_WIDTH-1:0] w_min;
    logic [DATA_WIDTH-1:0] w_nz;

    always_comb begin
        w_sum = '0;
        w_max = i_vec[0];
        w_min = i_vec[0];
        w_nz  = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + i_vec[i];
            if ($signed(i_vec[i]) > $signed(w_max)) w_max = i_vec[i];
            if ($signed(i_vec[i]) < $signed(w_min)) w_min = i_vec[i];
            if (i_vec[i] != '0) w_nz = w_nz + DATA_WIDTH'(1);
        end
    end

    always_comb begin
        case (i_op)
            OP_SUM:   o_result = w_sum;
            OP_MAX:   o_result = w_max;
            OP_MIN:   o_result = w_min;
            OP_NZCNT: o_result = w_nz;
            default:  o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/vector_reduce_packer.sv
// ============================================================================
// Module      : vector_reduce_packer
// Description : Per-chain bypass or reduce-and-pack of ALU trace vectors, 2-cycle latency.
//               Optional VECTOR_REDUCE_PACKER_STATS_EN adds a 16-bit pack_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_reduce_packer
    import vrp_pkg::*;
#(
    parameter int                      N                   = VRP_N,
    parameter int                      DATA_WIDTH          = 32,
    parameter int                      MAX_CHAINS          = 4,
    parameter int                      PERSONAL_CONFIG_ID  = 1,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_OP = '0
) (
    input  wire logic                clk,
    input  wire logic                reset,
    vector_reduce_packer_if.slave    bus
`ifdef VECTOR_REDUCE_PACKER_STATS_EN
    ,
    output logic [15:0]              pack_count
`endif
);

    localparam int CID_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

    // ---------------- firmware config ----------------
    logic [7:0]       r_fw_op [MAX_CHAINS];
    logic [CID_W-1:0] r_cfg_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < MAX_CHAINS; c++) r_fw_op[c] <= INITIAL_FIRMWARE_OP[c*8 +: 8];
            r_cfg_ptr <= '0;
        end else if (bus.configId == 8'(PERSONAL_CONFIG_ID)) begin
            r_fw_op[r_cfg_ptr] <= bus.configData;
            r_cfg_ptr <= (r_cfg_ptr == CID_W'(MAX_CHAINS-1)) ? '0 : r_cfg_ptr + 1'b1;
        end else begin
            r_cfg_ptr <= '0;
        end
    end

    // ---------------- stage 1 ----------------
    logic [7:0]            w_op;
    logic [DATA_WIDTH-1:0] w_scalar;
    logic                  r_s1_valid, r_s1_eof, r_s1_bof, r_s1_byp;
    logic [CID_W-1:0]      r_s1_cid;
    logic [DATA_WIDTH-1:0] r_s1_scalar;
    logic [DATA_WIDTH-1:0] r_s1_vec [N-1:0];

    assign w_op = r_fw_op[bus.chainId_in];

    vector_reduce_tree #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_tree (
        .i_op     (w_op),
        .i_vec    (bus.vector_in),
        .o_result (w_scalar)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_eof    <= 1'b0;
            r_s1_bof    <= 1'b0;
            r_s1_byp    <= 1'b0;
            r_s1_cid    <= '0;
            r_s1_scalar <= '0;
            for (int i = 0; i < N; i++) r_s1_vec[i] <= '0;
        end else begin
            r_s1_valid <= bus.tracing & bus.valid_in;
            if (bus.tracing) begin
                r_s1_eof    <= bus.eof_in;
                r_s1_bof    <= bus.bof_in;
                r_s1_byp    <= is_bypass(w_op);
                r_s1_cid    <= bus.chainId_in;
                r_s1_scalar <= w_scalar;
                r_s1_vec    <= bus.vector_in;
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [DATA_WIDTH-1:0] r_pack_buf [MAX_CHAINS][N];
    logic [CNT_W-1:0]      r_cnt      [MAX_CHAINS];
    logic                  r_first_bof[MAX_CHAINS];
    logic [CNT_W-1:0]      w_cnt;
    logic                  w_fire, w_emit, w_first_bof;
    logic [DATA_WIDTH-1:0] w_packed [N-1:0];

    logic                  r_valid_out, r_eof_out, r_bof_out;
    logic [CID_W-1:0]      r_cid_out;
    logic [DATA_WIDTH-1:0] r_vector_out [N-1:0];

    assign w_fire      = r_s1_valid & bus.tracing;
    assign w_cnt       = r_cnt[r_s1_cid];
    assign w_emit      = (w_cnt == CNT_W'(N-1)) | r_s1_eof;
    assign w_first_bof = (w_cnt == '0) ? r_s1_bof : r_first_bof[r_s1_cid];

    // The emitted vector includes the scalar arriving this cycle; lanes beyond it read as zero.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_packed[i] = '0;
            if (CNT_W'(i) < w_cnt)       w_packed[i] = r_pack_buf[r_s1_cid][i];
            else if (CNT_W'(i) == w_cnt) w_packed[i] = r_s1_scalar;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_eof_out   <= 1'b0;
            r_bof_out   <= 1'b0;
            r_cid_out   <= '0;
            for (int i = 0; i < N; i++) r_vector_out[i] <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                r_cnt[c]       <= '0;
                r_first_bof[c] <= 1'b0;
                for (int i = 0; i < N; i++) r_pack_buf[c][i] <= '0;
            end
        end else begin
            r_valid_out <= 1'b0;
            if (w_fire) begin
                if (r_s1_byp) begin
                    r_valid_out  <= 1'b1;
                    r_vector_out <= r_s1_vec;
                    r_cid_out    <= r_s1_cid;
                    r_eof_out    <= r_s1_eof;
                    r_bof_out    <= r_s1_bof;
                end else begin
                    r_pack_buf[r_s1_cid][w_cnt] <= r_s1_scalar;
                    if (w_cnt == '0) r_first_bof[r_s1_cid] <= r_s1_bof;
                    if (w_emit) begin
                        r_valid_out     <= 1'b1;
                        r_vector_out    <= w_packed;
                        r_cid_out       <= r_s1_cid;
                        r_eof_out       <= r_s1_eof;
                        r_bof_out       <= w_first_bof;
                        r_cnt[r_s1_cid] <= '0;
                    end else begin
                        r_cnt[r_s1_cid] <= w_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.valid_out   = r_valid_out;
    assign bus.eof_out     = r_eof_out;
    assign bus.bof_out     = r_bof_out;
    assign bus.chainId_out = r_cid_out;
    assign bus.vector_out  = r_vector_out;

`ifdef VECTOR_REDUCE_PACKER_STATS_EN
    logic [15:0] r_pack_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pack_count <= '0;
        end else if (w_fire && !r_s1_byp && w_emit && (r_pack_count != 16'hFFFF)) begin
            r_pack_count <= r_pack_count + 16'd1;
        end
    end

    assign pack_count = r_pack_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_reduce_packer.sv
// ============================================================================
// Module      : tb_vector_reduce_packer
// Description : Directed plus random stimulus against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_reduce_packer;
    import vrp_pkg::*;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int MC    = 4;
    localparam int CID_W = $clog2(MC);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vector_reduce_packer_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) bus ();
`ifdef VECTOR_REDUCE_PACKER_STATS_EN
    logic [15:0] pack_count;
`endif

    vector_reduce_packer #(
        .N                   (N),
        .DATA_WIDTH          (DW),
        .MAX_CHAINS          (MC),
        .PERSONAL_CONFIG_ID  (1),
        .INITIAL_FIRMWARE_OP ('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef VECTOR_REDUCE_PACKER_STATS_EN
        ,
        .pack_count (pack_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // reference model state
    logic [7:0]    m_op [MC];
    int            m_ptr;
    logic [DW-1:0] m_q [MC][$];
    bit            m_fbof [MC];
    int            m_packs;

    // the input accepted at the previous edge, already reduced under the op then in force
    bit            p_valid, p_byp, p_eof, p_bof;
    int            p_cid;
    logic [DW-1:0] p_scalar;
    logic [DW-1:0] p_vec [N];

    logic [DW-1:0] sv [N];
    logic [DW-1:0] last_vec [N];
    bit            last_eof, last_bof;
    int            last_cid;

    function automatic logic [DW-1:0] ref_reduce(input logic [7:0] op);
        logic [DW-1:0] acc;
        int            m;
        acc = '0;
        m   = $signed(sv[0]);
        case (op)
            8'd1: begin
                for (int i = 0; i < N; i++) acc = acc + sv[i];
                return acc;
            end
            8'd2: begin
                for (int i = 1; i < N; i++) if ($signed(sv[i]) > m) m = $signed(sv[i]);
                return DW'(m);
            end
            8'd3: begin
                for (int i = 1; i < N; i++) if ($signed(sv[i]) < m) m = $signed(sv[i]);
                return DW'(m);
            end
            8'd4: begin
                for (int i = 0; i < N; i++) if (sv[i] != 0) acc = acc + 1;
                return acc;
            end
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < MC; c++) begin
            m_op[c] = 8'd0;
            m_q[c].delete();
            m_fbof[c] = 1'b0;
        end
        m_ptr = 0;
        m_packs = 0;
        p_valid = 1'b0;
    endtask

    task automatic step(input bit tr, input bit v, input bit e, input bit b, input int cid,
                        input logic [7:0] cfid, input logic [7:0] cfd);
        bit            ev, eeof, ebof;
        int            ecid;
        logic [DW-1:0] evec [N];
        bus.tracing    = tr;
        bus.valid_in   = v;
        bus.eof_in     = e;
        bus.bof_in     = b;
        bus.chainId_in = CID_W'(cid);
        bus.configId   = cfid;
        bus.configData = cfd;
        for (int i = 0; i < N; i++) bus.vector_in[i] = sv[i];
        @(posedge clk);
        #1;
        ev = 0; eeof = 0; ebof = 0; ecid = 0;
        for (int i = 0; i < N; i++) evec[i] = '0;
        if (p_valid && tr) begin
            if (p_byp) begin
                ev = 1; evec = p_vec; eeof = p_eof; ebof = p_bof; ecid = p_cid;
            end else begin
                if (m_q[p_cid].size() == 0) m_fbof[p_cid] = p_bof;
                m_q[p_cid].push_back(p_scalar);
                if (m_q[p_cid].size() == N || p_eof) begin
                    ev = 1; eeof = p_eof; ebof = m_fbof[p_cid]; ecid = p_cid;
                    for (int i = 0; i < N; i++) evec[i] = (i < m_q[p_cid].size()) ? m_q[p_cid][i] : '0;
                    m_q[p_cid].delete();
                    if (m_packs < 65535) m_packs++;
                end
            end
        end
        check_eq("valid_out", bus.valid_out, ev);
        if (ev) begin
            check_eq("chainId_out", bus.chainId_out, ecid);
            check_eq("eof_out", bus.eof_out, eeof);
            check_eq("bof_out", bus.bof_out, ebof);
            for (int i = 0; i < N; i++) check_eq($sformatf("vector_out[%0d]", i), bus.vector_out[i], evec[i]);
        end
        if (bus.valid_out) begin
            for (int i = 0; i < N; i++) last_vec[i] = bus.vector_out[i];
            last_eof = bus.eof_out;
            last_bof = bus.bof_out;
            last_cid = int'(bus.chainId_out);
        end
`ifdef VECTOR_REDUCE_PACKER_STATS_EN
        check_eq("pack_count", pack_count, m_packs);
`endif
        p_valid = tr && v;
        if (tr) begin
            p_byp    = (m_op[cid] == 8'd0) || (m_op[cid] > 8'd4);
            p_eof    = e;
            p_bof    = b;
            p_cid    = cid;
            p_scalar = ref_reduce(m_op[cid]);
            p_vec    = sv;
        end
        if (cfid == 8'd1) begin
            m_op[m_ptr] = cfd;
            m_ptr = (m_ptr + 1) % MC;
        end else begin
            m_ptr = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 8'd0, 8'd0);
    endtask

    task automatic cfg(input logic [7:0] d);
        step(1, 0, 0, 0, 0, 8'd1, d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.tracing = 1'b0; bus.valid_in = 1'b0; bus.eof_in = 1'b0; bus.bof_in = 1'b0;
        bus.chainId_in = '0; bus.configId = 8'd0; bus.configData = 8'd0;
        @(posedge clk);
        #1;
        check_eq("rst valid_out", bus.valid_out, 0);
        check_eq("rst eof_out", bus.eof_out, 0);
        check_eq("rst bof_out", bus.bof_out, 0);
        check_eq("rst chainId_out", bus.chainId_out, 0);
        check_eq("rst vector_out[0]", bus.vector_out[0], 0);
        check_eq("rst vector_out[7]", bus.vector_out[7], 0);
`ifdef VECTOR_REDUCE_PACKER_STATS_EN
        check_eq("rst pack_count", pack_count, 0);
`endif
        model_reset();
        reset = 1'b0;
    endtask

    task automatic set_all(input logic [DW-1:0] val);
        for (int i = 0; i < N; i++) sv[i] = val;
    endtask

    initial begin
        for (int i = 0; i < N; i++) sv[i] = '0;
        do_reset();

        // config pointer: bytes 0..3, a gap, then one byte lands on chain 0 again
        cfg(8'd0); cfg(8'd1); cfg(8'd2); cfg(8'd3);
        idle(1);
        cfg(8'd3);
        idle(1);
        for (int i = 0; i < N; i++) sv[i] = $urandom;
        step(1, 1, 1, 1, 0, 8'd0, 8'd0);
        step(1, 1, 0, 0, 3, 8'd0, 8'd0);
        idle(2);

        // chain ops: 0 bypass, 1 sum, 2 max, 3 bypass
        cfg(8'd0); cfg(8'd1); cfg(8'd2); cfg(8'd0);
        idle(1);

        for (int i = 0; i < N; i++) sv[i] = DW'(i + 1);
        step(1, 1, 0, 0, 0, 8'd0, 8'd0);
        idle(2);
        check_eq("bypass lane0", last_vec[0], 1);
        check_eq("bypass lane7", last_vec[7], 8);
        check_eq("bypass chain", last_cid, 0);

        for (int k = 1; k <= N; k++) begin
            set_all(DW'(k));
            step(1, 1, 0, (k == 1), 1, 8'd0, 8'd0);
        end
        idle(2);
        check_eq("sum lane0", last_vec[0], 8);
        check_eq("sum lane7", last_vec[7], 64);
        check_eq("sum bof", last_bof, 1);
        check_eq("sum eof", last_eof, 0);

        for (int i = 0; i < N; i++) sv[i] = DW'(-(5 + int'($urandom_range(0, 50))));
        sv[3] = DW'(-5);
        step(1, 1, 0, 0, 2, 8'd0, 8'd0);
        for (int i = 0; i < N; i++) sv[i] = DW'(-int'($urandom_range(1, 1000)));
        sv[5] = 32'd7;
        step(1, 1, 0, 0, 2, 8'd0, 8'd0);
        for (int i = 0; i < N; i++) sv[i] = DW'(-int'($urandom_range(1, 1000)));
        sv[0] = 32'd0;
        step(1, 1, 1, 0, 2, 8'd0, 8'd0);
        idle(2);
        check_eq("max lane0", last_vec[0], 32'hFFFF_FFFB);
        check_eq("max lane1", last_vec[1], 7);
        check_eq("max lane2", last_vec[2], 0);
        check_eq("max lane3", last_vec[3], 0);
        check_eq("max eof", last_eof, 1);
        check_eq("max chain", last_cid, 2);

        // interleave: a bypass chain between two packed scalars of chain 1
        set_all(32'd2);
        step(1, 1, 0, 1, 1, 8'd0, 8'd0);
        for (int i = 0; i < N; i++) sv[i] = DW'(100 + i);
        step(1, 1, 1, 0, 3, 8'd0, 8'd0);
        set_all(32'd3);
        step(1, 1, 1, 0, 1, 8'd0, 8'd0);
        idle(2);
        check_eq("interleave lane1", last_vec[1], 24);
        check_eq("interleave lane2", last_vec[2], 0);

        // tracing low holds partial buffers and drops inputs
        set_all(32'd1);
        step(1, 1, 0, 0, 1, 8'd0, 8'd0);
        step(1, 1, 0, 0, 1, 8'd0, 8'd0);
        step(0, 1, 1, 0, 1, 8'd0, 8'd0);
        step(0, 1, 1, 0, 1, 8'd0, 8'd0);
        step(1, 1, 1, 0, 1, 8'd0, 8'd0);
        idle(2);

        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) sv[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 6) == 0),
                 $urandom_range(0, 1), int'($urandom_range(0, MC - 1)),
                 ($urandom_range(0, 15) == 0) ? 8'd1 : 8'd0, 8'($urandom_range(0, 6)));
        end
        idle(2);

        // reset with a partial buffer on chain 1
        do_reset();
        cfg(8'd0); cfg(8'd1); idle(1);
        set_all(32'd9);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 1, 8'd0, 8'd0);
        do_reset();
        cfg(8'd0); cfg(8'd1); idle(1);
        for (int k = 1; k <= N; k++) begin
            set_all(DW'(k));
            step(1, 1, 0, 0, 1, 8'd0, 8'd0);
        end
        idle(2);
        check_eq("post-reset lane0", last_vec[0], 8);
        check_eq("post-reset lane7", last_vec[7], 64);
`ifdef VECTOR_REDUCE_PACKER_STATS_EN
        check_eq("post-reset pack_count", pack_count, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
